load_line: RTL and testbench

LOAD_LINE -- requirements
Module: load_line

---
 rtl/load_line.sv | 97 +++++++++
 tb/tb_load_line.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/load_line.sv
// Cache line fill engine: arbitrates for the system bus, issues one read
// request for a 64-byte line and assembles the returned beats into a line.
module load_line #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned BEATS          = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [BUS_DATA_WIDTH-1:0]          addr,
    output logic                               abtr_reqcyc,
    input  logic                               abtr_grant,
    output logic                               bus_busy,
    output logic                               main_bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]          main_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]           main_bus_reqtag,
    input  logic                               main_bus_reqack,
    input  logic                               main_bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]          main_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]           main_bus_resptag,
    output logic                               main_bus_respack,
    output logic                               ready,
    output logic [BUS_DATA_WIDTH*BEATS-1:0]    data
);

    localparam int unsigned LINE_OFFSET_W = 6;
    localparam int unsigned SYSBUS_READ   = 1;
    localparam int unsigned SYSBUS_MEMORY = 1;
    localparam logic [BUS_TAG_WIDTH-1:0] READ_MEM_TAG =
        BUS_TAG_WIDTH'((SYSBUS_READ << 12) | (SYSBUS_MEMORY << 8));
    localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADDR,
        RECV,
        DONE
    } state_t;

    state_t                    state;
    logic [3:0]                beat;
    logic [BUS_DATA_WIDTH-1:0] line_addr;

    // State, beat counter, line address and line data
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= 4'd0;
            line_addr <= '0;
            data      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (enable) begin
                        state     <= ARB;
                        line_addr <= {addr[BUS_DATA_WIDTH-1:LINE_OFFSET_W], LINE_OFFSET_W'(0)};
                    end
                end
                ARB: begin
                    if (abtr_grant) state <= ADDR;
                end
                ADDR: begin
                    if (main_bus_reqack) begin
                        state <= RECV;
                        beat  <= 4'd0;
                    end
                end
                RECV: begin
                    if (main_bus_respcyc) begin
                        data[beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= main_bus_resp;
                        beat <= beat + 4'd1;
                        if (beat == LAST_BEAT) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus-facing outputs decode from the state register alone
    assign abtr_reqcyc     = (state == ARB);
    assign bus_busy        = (state == ADDR) || (state == RECV);
    assign main_bus_reqcyc = (state == ADDR);
    assign main_bus_req    = (state == ADDR) ? line_addr : '0;
    assign main_bus_reqtag = (state == ADDR) ? READ_MEM_TAG : '0;
    assign ready           = (state == DONE);

    // A reset cycle must not acknowledge a beat it is about to discard
    assign main_bus_respack = (state == RECV) && main_bus_respcyc && !reset;

    // Single outstanding request: response tag and line offset are not needed
    logic unused;
    assign unused = ^{main_bus_resptag, addr[LINE_OFFSET_W-1:0]};

endmodule

// File: tb/tb_load_line.sv
// Directed-plus-random bench for load_line: drives arbiter and bus responder
// and checks timing, request contents and the assembled line.
module tb_load_line;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [63:0]   addr;
    logic          abtr_reqcyc;
    logic          abtr_grant;
    logic          bus_busy;
    logic          main_bus_reqcyc;
    logic [63:0]   main_bus_req;
    logic [12:0]   main_bus_reqtag;
    logic          main_bus_reqack;
    logic          main_bus_respcyc;
    logic [63:0]   main_bus_resp;
    logic [12:0]   main_bus_resptag;
    logic          main_bus_respack;
    logic          ready;
    logic [511:0]  data;

    localparam logic [12:0] TAG_RD_MEM = 13'h1100;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  in_done  = 1'b0;

    always #5 clk = ~clk;

    load_line dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .addr             (addr),
        .abtr_reqcyc      (abtr_reqcyc),
        .abtr_grant       (abtr_grant),
        .bus_busy         (bus_busy),
        .main_bus_reqcyc  (main_bus_reqcyc),
        .main_bus_req     (main_bus_req),
        .main_bus_reqtag  (main_bus_reqtag),
        .main_bus_reqack  (main_bus_reqack),
        .main_bus_respcyc (main_bus_respcyc),
        .main_bus_resp    (main_bus_resp),
        .main_bus_resptag (main_bus_resptag),
        .main_bus_respack (main_bus_respack),
        .ready            (ready),
        .data             (data)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // One complete fill; rst_at >= 0 aborts with reset while beat rst_at is offered
    task automatic fill(input logic [63:0] a, input int gdly, input int adly, input int gap,
                        input int rst_at, input bit noise, input bit fixed);
        logic [63:0]  beats [8];
        logic [511:0] exp_line;
        logic [63:0]  exp_addr;
        int c, n_arb, n_req, n_ack;
        bit arb_ok, req_ok, recv_ok;
        exp_addr = a & ~64'h3F;
        for (int k = 0; k < 8; k++) begin
            beats[k] = fixed ? 64'(64'h11 * (k + 1)) : rand64();
            exp_line[k*64 +: 64] = beats[k];
        end
        n_arb = 0; n_req = 0; n_ack = 0;
        arb_ok = 1'b1; req_ok = 1'b1; recv_ok = 1'b1;

        enable = 1'b1; addr = a; abtr_grant = 1'b0; main_bus_reqack = 1'b0; main_bus_respcyc = 1'b0;
        @(negedge clk);
        check("ready_before_start", 512'(ready), 512'(in_done));
        tick(); c = 1;
        if (!noise) enable = 1'b0;
        addr = rand64();

        for (int i = 0; i <= gdly; i++) begin
            abtr_grant = (i == gdly);
            main_bus_respcyc = 1'b1; main_bus_resp = rand64(); main_bus_resptag = 13'($urandom);
            @(negedge clk);
            n_arb += int'(abtr_reqcyc);
            if (bus_busy || main_bus_reqcyc || main_bus_respack || ready) arb_ok = 1'b0;
            tick(); c++;
        end
        abtr_grant = 1'b0;
        for (int j = 0; j <= adly; j++) begin
            main_bus_reqack = (j == adly);
            main_bus_resp = rand64();
            @(negedge clk);
            n_req += int'(main_bus_reqcyc);
            if (main_bus_req !== exp_addr || main_bus_reqtag !== TAG_RD_MEM || !bus_busy ||
                abtr_reqcyc || main_bus_respack || ready) req_ok = 1'b0;
            tick(); c++;
        end
        main_bus_reqack = 1'b0;

        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < gap; g++) begin
                main_bus_respcyc = 1'b0; main_bus_resp = rand64();
                @(negedge clk);
                n_ack += int'(main_bus_respack);
                if (!bus_busy || main_bus_reqcyc || main_bus_req !== 64'd0) recv_ok = 1'b0;
                tick(); c++;
            end
            main_bus_respcyc = 1'b1; main_bus_resp = beats[k];
            if (k == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                check("respack_during_reset", 512'(main_bus_respack), 512'(0));
                tick();
                reset = 1'b0; main_bus_respcyc = 1'b0; enable = 1'b0;
                @(negedge clk);
                check("outputs_after_abort",
                      512'({ready, abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_respack,
                            main_bus_req, main_bus_reqtag}), 512'(0));
                check("data_after_abort", data, 512'(0));
                in_done = 1'b0;
                tick();
                return;
            end
            @(negedge clk);
            n_ack += int'(main_bus_respack);
            if (!bus_busy || main_bus_reqcyc || main_bus_req !== 64'd0 || ready) recv_ok = 1'b0;
            tick(); c++;
        end
        main_bus_respcyc = 1'b0; enable = 1'b0;

        @(negedge clk);
        check("ready_in_done", 512'(ready), 512'(1));
        check("enable_to_ready_cycles", 512'(c), 512'(3 + gdly + adly + 8 * (1 + gap)));
        check("line_data", data, exp_line);
        check("abtr_reqcyc_cycles", 512'(n_arb), 512'(gdly + 1));
        check("reqcyc_cycles", 512'(n_req), 512'(adly + 1));
        check("respack_pulses", 512'(n_ack), 512'(8));
        check("arb_phase_outputs", 512'(arb_ok), 512'(1));
        check("addr_phase_request", 512'(req_ok), 512'(1));
        check("recv_phase_outputs", 512'(recv_ok), 512'(1));
        check("bus_busy_in_done", 512'(bus_busy), 512'(0));
        if (fixed) begin
            check("data_beat0", 512'(data[63:0]), 512'(64'h11));
            check("data_beat7", 512'(data[511:448]), 512'(64'h88));
        end

        for (int i = 0; i < 2; i++) begin
            tick();
            main_bus_respcyc = 1'b1; main_bus_resp = rand64();
            @(negedge clk);
            check("respack_in_done", 512'(main_bus_respack), 512'(0));
        end
        tick();
        main_bus_respcyc = 1'b0;
        @(negedge clk);
        check("data_held_in_done", data, exp_line);
        check("ready_held_in_done", 512'(ready), 512'(1));
        in_done = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; addr = '0; abtr_grant = 1'b0; main_bus_reqack = 1'b0;
        main_bus_respcyc = 1'b0; main_bus_resp = '0; main_bus_resptag = '0;
        tick(); tick();
        @(negedge clk);
        check("reset_outputs",
              512'({ready, abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_respack,
                    main_bus_req, main_bus_reqtag}), 512'(0));
        check("reset_data", data, 512'(0));
        tick();
        reset = 1'b0;
        tick();

        fill(64'h1234_5678_9ABC_DEF7, 0, 0, 0, -1, 1'b0, 1'b1);
        fill(rand64(), 5, 3, 0, -1, 1'b0, 1'b0);
        fill(rand64(), 0, 0, 2, -1, 1'b0, 1'b0);
        fill(rand64(), 0, 0, 0, 4, 1'b0, 1'b0);
        fill(rand64(), 1, 1, 0, -1, 1'b0, 1'b0);
        fill(rand64(), 0, 0, 0, -1, 1'b1, 1'b0);
        fill(rand64(), 2, 1, 1, -1, 1'b1, 1'b0);
        for (int r = 0; r < 6; r++) begin
            fill(rand64(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), -1, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
